// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants for the SPI master: default transfer
//               geometry, SPI mode and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default transfer geometry (overridable per instance)
  localparam int unsigned SPI_DATA_SIZE_DEF = 8;
  localparam int unsigned CLK_DIV_DEF       = 4;
  localparam int unsigned CS_SETUP_DEF      = 2;
  localparam int unsigned CS_HOLD_DEF       = 2;
  localparam int unsigned CS_GAP_DEF        = 4;

  // Mode 0: CPOL=0 (SCLK idles low), CPHA=0 (sample on rising edge)
  localparam logic [1:0] SPI_MODE = 2'd0;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_SCLK_LO = 3'd2;
  localparam logic [2:0] ST_SCLK_HI = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_SCLK_LO = ST_SCLK_LO,
    S_SCLK_HI = ST_SCLK_HI,
    S_HOLD    = ST_HOLD,
    S_GAP     = ST_GAP
  } spi_state_e;

  // Largest of three cycle counts, used to size the phase counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : Half-period counter for the SPI master. While enabled it
//               counts CLK_DIV fabric cycles per SCLK half period and raises
//               tick_lo / tick_hi in the last cycle of a low / high half.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,       // asynchronous, active low
  input  logic i_en,        // FSM is in a SCLK half-period state
  input  logic i_phase_hi,  // current half period is the high one
  output logic o_tick_lo,
  output logic o_tick_hi
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  // Count within a half period; restart at zero whenever disabled or wrapping
  always_comb begin
    last  = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d = '0;
    if (i_en && !last) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick_lo = i_en & last & ~i_phase_hi;
  assign o_tick_hi = i_en & last &  i_phase_hi;

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master, MSB first, one word per i_start. All
//               outputs registered. Optional macro SPI_MASTER_BURST_EN chains
//               a new word from the last HOLD cycle without releasing SSEL.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned SPI_DATA_SIZE = SPI_DATA_SIZE_DEF,
  parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
  parameter int unsigned CS_SETUP      = CS_SETUP_DEF,
  parameter int unsigned CS_HOLD       = CS_HOLD_DEF,
  parameter int unsigned CS_GAP        = CS_GAP_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,        // asynchronous, active low
  input  logic                     i_start,
  input  logic [SPI_DATA_SIZE-1:0] i_spi_data_tx,
  input  logic                     i_MISO,
  output logic                     o_SCLK,
  output logic                     o_SSEL,
  output logic                     o_MOSI,
  output logic [SPI_DATA_SIZE-1:0] o_spi_data_rx,
  output logic                     o_spi_ready,
  output logic                     o_spi_busy
);

  localparam int unsigned W     = SPI_DATA_SIZE;
  localparam int unsigned CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP));
  localparam int unsigned BIT_W = $clog2(W + 1);

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [W-1:0]     tx_q, tx_d;
  logic [W-1:0]     rx_q, rx_d;
  logic [W-1:0]     data_rx_q, data_rx_d;
  logic             sclk_q, sclk_d;
  logic             ssel_q, ssel_d;
  logic             mosi_q, mosi_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             tick_lo, tick_hi;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       ((state_q == S_SCLK_LO) || (state_q == S_SCLK_HI)),
    .i_phase_hi (state_q == S_SCLK_HI),
    .o_tick_lo  (tick_lo),
    .o_tick_hi  (tick_hi)
  );

  // Next-state and next-output logic; outputs are set one cycle ahead so
  // every pin comes straight from a flop
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    sclk_d    = sclk_q;
    ssel_d    = ssel_q;
    mosi_d    = mosi_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          tx_d     = i_spi_data_tx;
          rx_d     = '0;
          bitcnt_d = '0;
          cnt_d    = '0;
          ssel_d   = 1'b0;
          busy_d   = 1'b1;
          mosi_d   = i_spi_data_tx[W-1];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_SCLK_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCLK_LO: begin
        if (tick_lo) begin
          sclk_d  = 1'b1;
          state_d = S_SCLK_HI;
        end
      end
      S_SCLK_HI: begin
        // Sample MISO at the end of the high half, just before SCLK falls
        if (tick_hi) begin
          rx_d     = {rx_q[W-2:0], i_MISO};
          tx_d     = tx_q << 1;
          bitcnt_d = bitcnt_q + 1'b1;
          sclk_d   = 1'b0;
          if (bitcnt_q == BIT_W'(W - 1)) begin
            mosi_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            mosi_d  = tx_d[W-1];
            state_d = S_SCLK_LO;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          data_rx_d = rx_q;
          ready_d   = 1'b1;
          cnt_d     = '0;
`ifdef SPI_MASTER_BURST_EN
          if (i_start) begin
            tx_d     = i_spi_data_tx;
            rx_d     = '0;
            bitcnt_d = '0;
            mosi_d   = i_spi_data_tx[W-1];
            state_d  = S_SCLK_LO;
          end else begin
            ssel_d  = 1'b1;
            state_d = S_GAP;
          end
`else
          ssel_d  = 1'b1;
          state_d = S_GAP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      sclk_q    <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      sclk_q    <= sclk_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign o_SCLK        = sclk_q;
  assign o_SSEL        = ssel_q;
  assign o_MOSI        = mosi_q;
  assign o_spi_data_rx = data_rx_q;
  assign o_spi_ready   = ready_q;
  assign o_spi_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Bench for spi_master. dut_a uses default parameters, dut_b
//               uses SPI_DATA_SIZE=16, CLK_DIV=2. Behaviour of the burst
//               test follows SPI_MASTER_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        start;
  logic [15:0] tx;
  logic        miso;

  always #5 clk = ~clk;

  logic        a_start, b_start;
  logic        a_sclk, a_ssel, a_mosi, a_ready, a_busy;
  logic        b_sclk, b_ssel, b_mosi, b_ready, b_busy;
  logic [7:0]  a_rx;
  logic [15:0] b_rx;

  assign a_start = start & ~sel;
  assign b_start = start &  sel;

  spi_master dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_start(a_start), .i_spi_data_tx(tx[7:0]),
    .i_MISO(miso), .o_SCLK(a_sclk), .o_SSEL(a_ssel), .o_MOSI(a_mosi),
    .o_spi_data_rx(a_rx), .o_spi_ready(a_ready), .o_spi_busy(a_busy)
  );

  spi_master #(.SPI_DATA_SIZE(16), .CLK_DIV(2)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_start(b_start), .i_spi_data_tx(tx),
    .i_MISO(miso), .o_SCLK(b_sclk), .o_SSEL(b_ssel), .o_MOSI(b_mosi),
    .o_spi_data_rx(b_rx), .o_spi_ready(b_ready), .o_spi_busy(b_busy)
  );

  logic        w_sclk, w_ssel, w_mosi, w_ready, w_busy;
  logic [15:0] w_rx;
  assign w_sclk  = sel ? b_sclk  : a_sclk;
  assign w_ssel  = sel ? b_ssel  : a_ssel;
  assign w_mosi  = sel ? b_mosi  : a_mosi;
  assign w_ready = sel ? b_ready : a_ready;
  assign w_busy  = sel ? b_busy  : a_busy;
  assign w_rx    = sel ? b_rx    : {8'h00, a_rx};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One complete transfer on the selected DUT, observed cycle by cycle.
  // The bench plays a mode-0 slave: it presents bit (W-1-k) on MISO after the
  // k-th SCLK falling edge, or echoes MOSI when lb is set.
  task automatic run(input bit s, input logic [15:0] t, input logic [15:0] slave,
                     input bit lb, input bit poke, input logic [15:0] exp_rx,
                     input string nm);
    int w, dv, exp_ready, exp_first;
    int ssel_fall_c, ssel_fall_n, ssel_rise, ssel_lo_n;
    int first, rises, falls, last_rise, per_err, mosi_err, glitch;
    int ready_n, ready_c, busy_f, hold_err;
    logic [15:0] prev_rx, rx_at, mask;
    logic p_ssel, p_sclk;
    w = s ? 16 : 8;
    dv = s ? 2 : 4;
    mask = s ? 16'hFFFF : 16'h00FF;
    exp_ready = 1 + 2 + 2 * dv * w + 2;
    exp_first = 1 + 2 + dv;
    ssel_fall_c = -1; ssel_fall_n = 0; ssel_rise = -1; ssel_lo_n = 0;
    first = -1; rises = 0; falls = 0; last_rise = -1; per_err = 0;
    mosi_err = 0; glitch = 0; ready_n = 0; ready_c = -1; busy_f = -1; hold_err = 0;
    rx_at = '0; p_ssel = 1'b1; p_sclk = 1'b0;
    sel = s;
    @(negedge clk);
    prev_rx = w_rx;
    tx = t;
    start = 1'b1;
    miso = lb ? 1'b0 : slave[w-1];
    for (int rel = 1; rel <= 400 && busy_f < 0; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        start = 1'b0;
        tx = 16'($urandom);
      end
      if (poke && (rel == 20 || rel == 70)) begin
        start = 1'b1;
        tx = 16'hFFFF;
      end else if (poke && (rel == 21 || rel == 71)) begin
        start = 1'b0;
      end
      if (!w_ssel && p_ssel) begin
        ssel_fall_n++;
        if (ssel_fall_c < 0) ssel_fall_c = rel;
      end
      if (w_ssel && !p_ssel && ssel_rise < 0) ssel_rise = rel;
      if (!w_ssel) ssel_lo_n++;
      if (w_sclk && !p_sclk) begin
        if (first < 0) first = rel;
        else if (rel - last_rise != 2 * dv) per_err++;
        last_rise = rel;
        if (rises < w && w_mosi != t[w-1-rises]) mosi_err++;
        rises++;
      end
      if (!w_sclk && p_sclk) falls++;
      if (w_sclk && w_ssel) glitch++;
      if (w_ssel && w_mosi) mosi_err++;
      if (w_ready) begin
        ready_n++;
        ready_c = rel;
        rx_at = w_rx;
      end else if (ready_n == 0 && w_rx != prev_rx) begin
        hold_err++;
      end else if (ready_n > 0 && w_rx != rx_at) begin
        hold_err++;
      end
      if (!w_busy) busy_f = rel;
      p_ssel = w_ssel;
      p_sclk = w_sclk;
      miso = lb ? w_mosi : ((falls < w) ? slave[w-1-falls] : 1'b0);
    end
    chk({nm, " ssel_fall_cycle"}, ssel_fall_c, 1);
    chk({nm, " ssel_frames"}, ssel_fall_n, 1);
    chk({nm, " ssel_rise_cycle"}, ssel_rise, exp_ready);
    chk({nm, " ssel_low_cycles"}, ssel_lo_n, exp_ready - 1);
    chk({nm, " first_rise"}, first, exp_first);
    chk({nm, " sclk_rises"}, rises, w);
    chk({nm, " sclk_period_err"}, per_err, 0);
    chk({nm, " mosi_err"}, mosi_err, 0);
    chk({nm, " sclk_glitch"}, glitch, 0);
    chk({nm, " ready_pulses"}, ready_n, 1);
    chk({nm, " ready_cycle"}, ready_c, exp_ready);
    chk({nm, " rx_word"}, rx_at, exp_rx & mask);
    chk({nm, " busy_fall"}, busy_f, exp_ready + 4);
    chk({nm, " rx_hold_err"}, hold_err, 0);
  endtask

  typedef struct {
    bit          s;
    logic [15:0] tx;
    logic [15:0] slave;
    bit          lb;
    bit          poke;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; tx = '0; miso = 1'b0;
    vecs[0] = '{s: 1'b0, tx: 16'h00A5, slave: 16'h0000, lb: 1'b1, poke: 1'b0, exp_rx: 16'h00A5};
    vecs[1] = '{s: 1'b0, tx: 16'h0000, slave: 16'h00FF, lb: 1'b0, poke: 1'b0, exp_rx: 16'h00FF};
    vecs[2] = '{s: 1'b0, tx: 16'h0000, slave: 16'h0000, lb: 1'b0, poke: 1'b0, exp_rx: 16'h0000};
    vecs[3] = '{s: 1'b1, tx: 16'hBEEF, slave: 16'h0000, lb: 1'b1, poke: 1'b0, exp_rx: 16'hBEEF};
    vecs[4] = '{s: 1'b0, tx: 16'h003C, slave: 16'h0000, lb: 1'b1, poke: 1'b1, exp_rx: 16'h003C};

    repeat (3) @(negedge clk);
    chk("reset ssel", a_ssel, 1);
    chk("reset sclk", a_sclk, 0);
    chk("reset mosi", a_mosi, 0);
    chk("reset rx", a_rx, 0);
    chk("reset ready", a_ready, 0);
    chk("reset busy", a_busy, 0);
    chk("reset b_ssel", b_ssel, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run(vecs[i].s, vecs[i].tx, vecs[i].slave, vecs[i].lb, vecs[i].poke,
          vecs[i].exp_rx, $sformatf("vec%0d", i));

    // Asynchronous reset in the high half of bit 3 (a_rx currently 0x3C)
    sel = 1'b0;
    @(negedge clk);
    tx = 16'h00FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    chk("pre_reset sclk", a_sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst ssel", a_ssel, 1);
    chk("async_rst sclk", a_sclk, 0);
    chk("async_rst mosi", a_mosi, 0);
    chk("async_rst busy", a_busy, 0);
    chk("async_rst rx", a_rx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 16'h005A, 16'h0000, 1'b1, 1'b0, 16'h005A, "after_reset");

    // Randomised transfers against the slave/loopback model: the received
    // word is the slave's word, or the transmitted word under loopback
    for (int i = 0; i < 10; i++) begin
      bit          rs, rl;
      logic [15:0] rt, rv;
      rs = (i >= 7);
      rl = 1'($urandom_range(0, 1));
      rt = 16'($urandom);
      rv = 16'($urandom);
      run(rs, rt, rv, rl, 1'b0, rl ? rt : rv, $sformatf("rand%0d", i));
    end

    // i_start held high across two words, loopback
    begin
      int rdy, ssel_falls, hi_n, done;
      logic [7:0] rx1, rx2;
      logic p_ssel;
      rdy = 0; ssel_falls = 0; hi_n = 0; done = 0; rx1 = '0; rx2 = '0; p_ssel = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      tx = 16'h0012;
      start = 1'b1;
      miso = a_mosi;
      for (int rel = 1; rel <= 400 && done == 0; rel++) begin
        @(negedge clk);
        miso = a_mosi;
        if (rel == 2) tx = 16'h0034;
        if (!a_ssel && p_ssel) ssel_falls++;
        p_ssel = a_ssel;
        if (a_ready) begin
          rdy++;
          if (rdy == 1) rx1 = a_rx;
          else rx2 = a_rx;
        end
        if (rdy == 1 && a_ssel) hi_n++;
`ifdef SPI_MASTER_BURST_EN
        if (rdy >= 1) start = 1'b0;
`else
        if (ssel_falls >= 2) start = 1'b0;
`endif
        if (rdy == 2 && !a_busy) done = 1;
      end
      start = 1'b0;
      chk("burst ready_pulses", rdy, 2);
      chk("burst rx1", rx1, 8'h12);
      chk("burst rx2", rx2, 8'h34);
`ifdef SPI_MASTER_BURST_EN
      chk("burst ssel_high_between", hi_n, 0);
      chk("burst ssel_frames", ssel_falls, 1);
`else
      chk("burst ssel_gap_ge4", (hi_n >= 4) ? 1 : 0, 1);
      chk("burst ssel_frames", ssel_falls, 2);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
